// File: rtl/spi_multi_master_pkg.sv
// Shared types and helpers for the multi-slave SPI master.
// Holds the FSM state encoding and the word-length/divider clamps.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD,
    DONE
  } state_t;

  // Word length of 0 or above the maximum means a full-width word.
  function automatic int eff_len(input int n, input int max_len);
    return (n == 0 || n > max_len) ? max_len : n;
  endfunction

  // A half-period of 0 cycles is not meaningful; run it as 1.
  function automatic int eff_div(input int d);
    return (d == 0) ? 1 : d;
  endfunction

endpackage

// File: rtl/spi_clock_generator.sv
// SCLK divider: half-period tick, SCLK level and edge strobes.
// Counts the 2N edges of a transfer so the FSM knows when to stop.
module spi_clock_generator #(
  parameter int DW = 8,
  parameter int EW = 7
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          start_cpol,
  input  logic [EW-1:0] start_edges,
  input  logic [DW-1:0] div,
  input  logic          run,
  output logic          sclk,
  output logic          tick,
  output logic          lead,
  output logic          trail,
  output logic          final_edge,
  output logic          edges_done
);

  logic [DW-1:0] cnt;
  logic [EW-1:0] edges_left;
  logic          fire;

  assign tick       = (cnt == div - DW'(1));
  assign edges_done = (edges_left == '0);
  assign final_edge = (edges_left == EW'(1));
  assign fire       = run && tick && !edges_done;
  // An even count of remaining edges means SCLK is at CPOL.
  assign lead       = fire && !edges_left[0];
  assign trail      = fire && edges_left[0];

  // Half-period counter, SCLK level and remaining-edge count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      edges_left <= '0;
      sclk       <= 1'b0;
    end else if (start) begin
      cnt        <= '0;
      edges_left <= start_edges;
      sclk       <= start_cpol;
    end else begin
      cnt <= tick ? '0 : cnt + DW'(1);
      if (fire) begin
        sclk       <= ~sclk;
        edges_left <= edges_left - EW'(1);
      end
    end
  end

endmodule

// File: rtl/spi_multi_master.sv
// SPI master with N chip selects, runtime CPOL/CPHA and word length.
// Optional internal loopback when SPI_MULTI_MASTER_LOOPBACK_EN is defined.
module spi_multi_master
  import spi_pkg::*;
#(
  parameter int SPI_CLOCK_DIVIDER_WIDTH = 8,
  parameter int SPI_MAX_DATA_WIDTH      = 32,
  parameter int SPI_CS_COUNT            = 4
) (
  input  logic                                      i_clock,
  input  logic                                      i_reset,
  input  logic                                      i_enable,
  input  logic [$clog2(SPI_CS_COUNT+1)-1:0]         i_cs_index,
  input  logic                                      i_clock_polarity,
  input  logic                                      i_clock_phase,
  input  logic [SPI_CLOCK_DIVIDER_WIDTH-1:0]        i_spi_clock_divider,
  input  logic [$clog2(SPI_MAX_DATA_WIDTH+1)-1:0]   i_word_length,
  input  logic [SPI_MAX_DATA_WIDTH-1:0]             i_data_in,
  output logic [SPI_MAX_DATA_WIDTH-1:0]             o_data_out,
  output logic                                      o_done,
  output logic                                      o_busy,
  output logic [SPI_CS_COUNT-1:0]                   o_spi_cs_n,
  output logic                                      o_spi_clock,
  output logic                                      o_spi_mosi,
`ifdef SPI_MULTI_MASTER_LOOPBACK_EN
  input  logic                                      i_loopback,
`endif
  input  logic                                      i_spi_miso
);

  localparam int MW = SPI_MAX_DATA_WIDTH;
  localparam int DW = SPI_CLOCK_DIVIDER_WIDTH;
  localparam int CW = $clog2(SPI_CS_COUNT + 1);
  localparam int LW = $clog2(MW + 1);
  localparam int EW = LW + 1;

  state_t        state;
  state_t        state_next;
  logic [CW-1:0] cs_q;
  logic          cpha_q;
  logic [DW-1:0] div_q;
  logic [MW-1:0] tx_sr;
  logic [MW-1:0] rx_sr;
  logic          loopback_q;

  logic          start;
  logic          run;
  logic [LW-1:0] len_in;
  logic [DW-1:0] div_in;
  logic [MW-1:0] tx_aligned;
  logic [CW-1:0] cs_sel;
  logic          active_next;
  logic [SPI_CS_COUNT-1:0] cs_n_next;
  logic          shift_out;
  logic          sample;
  logic          rx_bit;

  logic tick, lead, trail, final_edge, edges_done;

  assign start  = (state == IDLE) && i_enable;
  assign run    = (state == SETUP) || (state == TRANSFER);
  assign len_in = LW'(eff_len(int'(i_word_length), MW));
  assign div_in = DW'(eff_div(int'(i_spi_clock_divider)));
  // Left-align so the first bit out (bit N-1) sits at the MSB.
  assign tx_aligned = i_data_in << (MW - int'(len_in));
  assign cs_sel     = start ? i_cs_index : cs_q;

  // CPHA=0 drives on trailing edges; the last one has no bit left.
  assign shift_out = cpha_q ? lead : (trail && !final_edge);
  assign sample    = cpha_q ? trail : lead;

`ifdef SPI_MULTI_MASTER_LOOPBACK_EN
  assign rx_bit = loopback_q ? o_spi_mosi : i_spi_miso;
`else
  assign rx_bit     = i_spi_miso;
  assign loopback_q = 1'b0;
`endif

  spi_clock_generator #(
    .DW(DW),
    .EW(EW)
  ) u_clk_gen (
    .clk         (i_clock),
    .rst         (i_reset),
    .start       (start),
    .start_cpol  (i_clock_polarity),
    .start_edges ({len_in, 1'b0}),
    .div         (div_q),
    .run         (run),
    .sclk        (o_spi_clock),
    .tick        (tick),
    .lead        (lead),
    .trail       (trail),
    .final_edge  (final_edge),
    .edges_done  (edges_done)
  );

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic: each phase ends on a half-period tick.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (i_enable) state_next = SETUP;
      SETUP:    if (tick) state_next = TRANSFER;
      TRANSFER: if (tick && edges_done) state_next = HOLD;
      HOLD:     if (tick) state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Chip-select decode for the coming cycle; out-of-range index selects none.
  always_comb begin
    cs_n_next   = '1;
    active_next = (state_next == SETUP) || (state_next == TRANSFER) ||
                  (state_next == HOLD);
    for (int i = 0; i < SPI_CS_COUNT; i++) begin
      if (active_next && cs_sel == CW'(i)) cs_n_next[i] = 1'b0;
    end
  end

  // Registered handshake, select and result outputs.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_spi_cs_n <= '1;
      o_done     <= 1'b0;
      o_busy     <= 1'b0;
      o_data_out <= '0;
    end else begin
      o_spi_cs_n <= cs_n_next;
      o_done     <= (state_next == DONE);
      o_busy     <= (state_next != IDLE);
      if (state_next == DONE) o_data_out <= rx_sr;
    end
  end

  // Transfer configuration latch and TX/RX shift registers.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      cs_q       <= '0;
      cpha_q     <= 1'b0;
      div_q      <= DW'(1);
      tx_sr      <= '0;
      rx_sr      <= '0;
      o_spi_mosi <= 1'b0;
`ifdef SPI_MULTI_MASTER_LOOPBACK_EN
      loopback_q <= 1'b0;
`endif
    end else if (start) begin
      cs_q   <= i_cs_index;
      cpha_q <= i_clock_phase;
      div_q  <= div_in;
      rx_sr  <= '0;
`ifdef SPI_MULTI_MASTER_LOOPBACK_EN
      loopback_q <= i_loopback;
`endif
      if (!i_clock_phase) begin
        o_spi_mosi <= tx_aligned[MW-1];
        tx_sr      <= tx_aligned << 1;
      end else begin
        tx_sr <= tx_aligned;
      end
    end else begin
      if (shift_out) begin
        o_spi_mosi <= tx_sr[MW-1];
        tx_sr      <= tx_sr << 1;
      end
      if (sample) rx_sr <= {rx_sr[MW-2:0], rx_bit};
    end
  end

endmodule

// File: tb/tb_spi_multi_master.sv
// Directed bench for spi_multi_master with a behavioural SPI slave.
// Loopback scenarios compile only with SPI_MULTI_MASTER_LOOPBACK_EN.
module tb_spi_multi_master;

  logic        clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_enable = 1'b0;
  logic [2:0]  i_cs_index = '0;
  logic        i_clock_polarity = 1'b0;
  logic        i_clock_phase = 1'b0;
  logic [7:0]  i_spi_clock_divider = 8'd1;
  logic [5:0]  i_word_length = '0;
  logic [31:0] i_data_in = '0;
  logic [31:0] o_data_out;
  logic        o_done;
  logic        o_busy;
  logic [3:0]  o_spi_cs_n;
  logic        o_spi_clock;
  logic        o_spi_mosi;
  logic        i_spi_miso = 1'b0;
`ifdef SPI_MULTI_MASTER_LOOPBACK_EN
  logic        i_loopback = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  spi_multi_master #(
    .SPI_CLOCK_DIVIDER_WIDTH(8),
    .SPI_MAX_DATA_WIDTH(32),
    .SPI_CS_COUNT(4)
  ) dut (
    .i_clock             (clk),
    .i_reset             (i_reset),
    .i_enable            (i_enable),
    .i_cs_index          (i_cs_index),
    .i_clock_polarity    (i_clock_polarity),
    .i_clock_phase       (i_clock_phase),
    .i_spi_clock_divider (i_spi_clock_divider),
    .i_word_length       (i_word_length),
    .i_data_in           (i_data_in),
    .o_data_out          (o_data_out),
    .o_done              (o_done),
    .o_busy              (o_busy),
    .o_spi_cs_n          (o_spi_cs_n),
    .o_spi_clock         (o_spi_clock),
    .o_spi_mosi          (o_spi_mosi),
`ifdef SPI_MULTI_MASTER_LOOPBACK_EN
    .i_loopback          (i_loopback),
`endif
    .i_spi_miso          (i_spi_miso)
  );

  // Starts a transfer from a negedge and plays the slave until o_done.
  // Returns at the negedge of the o_done cycle (done_cyc 0 = timed out).
  task automatic run_xfer(
    input  logic        hold,
    input  logic [2:0]  cs,
    input  logic        cpol,
    input  logic        cpha,
    input  logic [7:0]  div,
    input  logic [5:0]  len,
    input  logic [31:0] tx,
    input  logic [31:0] sw,
    input  logic        force_miso,
    output int          done_cyc,
    output int          edges,
    output logic [31:0] mosi_cap,
    output logic [3:0]  cs_first,
    output logic [3:0]  cs_and,
    output logic        busy_first
  );
    int   n;
    int   ptr;
    int   cyc;
    logic prev;
    logic lead;
    n = (len == 0 || len > 32) ? 32 : int'(len);
    i_cs_index          = cs;
    i_clock_polarity    = cpol;
    i_clock_phase       = cpha;
    i_spi_clock_divider = div;
    i_word_length       = len;
    i_data_in           = tx;
    i_spi_miso          = force_miso;
    i_enable            = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold) i_enable = 1'b0;
    ptr        = n - 1;
    edges      = 0;
    mosi_cap   = '0;
    done_cyc   = 0;
    cyc        = 1;
    cs_first   = o_spi_cs_n;
    cs_and     = 4'hF;
    busy_first = o_busy;
    prev       = o_spi_clock;
    if (!cpha && !force_miso) begin
      i_spi_miso = sw[ptr];
      ptr--;
    end
    while (cyc < 5000) begin
      cs_and &= o_spi_cs_n;
      if (o_spi_clock !== prev) begin
        edges++;
        lead = (prev === cpol);
        if (lead != cpha) mosi_cap = {mosi_cap[30:0], o_spi_mosi};
        if (lead == cpha && ptr >= 0) begin
          if (!force_miso) i_spi_miso = sw[ptr];
          ptr--;
        end
        prev = o_spi_clock;
      end
      if (o_done === 1'b1) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  int          dc;
  int          ed;
  logic [31:0] mc;
  logic [3:0]  csf;
  logic [3:0]  csa;
  logic        bf;

  task automatic test_reset();
    @(negedge clk);
    n_checks++;
    if (o_spi_cs_n !== 4'hF) begin
      n_errors++;
      $display("FAIL rst_cs got %h want F", o_spi_cs_n);
    end
    n_checks++;
    if (o_spi_clock !== 1'b0 || o_spi_mosi !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_pins sclk %b mosi %b want 0 0", o_spi_clock, o_spi_mosi);
    end
    n_checks++;
    if (o_data_out !== 32'h0) begin
      n_errors++;
      $display("FAIL rst_data got %h want 0", o_data_out);
    end
    n_checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_flags done %b busy %b want 0 0", o_done, o_busy);
    end
    i_reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_spi_cs_n !== 4'hF) begin
      n_errors++;
      $display("FAIL idle_after_rst busy %b cs %h want 0 F", o_busy, o_spi_cs_n);
    end
  endtask

  task automatic test_mode0();
    run_xfer(1'b0, 3'd1, 1'b0, 1'b0, 8'd2, 6'd8, 32'hA5, 32'h3C, 1'b0,
             dc, ed, mc, csf, csa, bf);
    n_checks++;
    if (bf !== 1'b1) begin
      n_errors++;
      $display("FAIL m0_busy1 got %b want 1", bf);
    end
    n_checks++;
    if (csf !== 4'b1101 || csa !== 4'b1101) begin
      n_errors++;
      $display("FAIL m0_cs first %b and %b want 1101", csf, csa);
    end
    n_checks++;
    if (mc !== 32'hA5) begin
      n_errors++;
      $display("FAIL m0_mosi got %h want a5", mc);
    end
    n_checks++;
    if (o_data_out !== 32'h0000003C) begin
      n_errors++;
      $display("FAIL m0_data got %h want 3c", o_data_out);
    end
    n_checks++;
    if (dc !== 37 || ed !== 16) begin
      n_errors++;
      $display("FAIL m0_timing done %0d edges %0d want 37 16", dc, ed);
    end
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0 || o_spi_cs_n !== 4'hF) begin
      n_errors++;
      $display("FAIL m0_end busy %b done %b cs %h want 0 0 F",
               o_busy, o_done, o_spi_cs_n);
    end
  endtask

  task automatic test_mode3();
    run_xfer(1'b0, 3'd0, 1'b1, 1'b1, 8'd1, 6'd0, 32'hDEADBEEF,
             32'h12345678, 1'b0, dc, ed, mc, csf, csa, bf);
    n_checks++;
    if (o_data_out !== 32'h12345678) begin
      n_errors++;
      $display("FAIL m3_data got %h want 12345678", o_data_out);
    end
    n_checks++;
    if (mc !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL m3_mosi got %h want deadbeef", mc);
    end
    n_checks++;
    if (dc !== 67 || ed !== 64) begin
      n_errors++;
      $display("FAIL m3_timing done %0d edges %0d want 67 64", dc, ed);
    end
    n_checks++;
    if (csf !== 4'b1110) begin
      n_errors++;
      $display("FAIL m3_cs got %b want 1110", csf);
    end
    @(negedge clk);
    n_checks++;
    if (o_spi_clock !== 1'b1 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL m3_idle sclk %b busy %b want 1 0", o_spi_clock, o_busy);
    end
  endtask

  task automatic test_word12();
    run_xfer(1'b0, 3'd2, 1'b0, 1'b0, 8'd1, 6'd12, 32'hFFFFFABC,
             32'hFFFFF5A3, 1'b0, dc, ed, mc, csf, csa, bf);
    n_checks++;
    if (o_data_out !== 32'h000005A3) begin
      n_errors++;
      $display("FAIL w12_data got %h want 5a3", o_data_out);
    end
    n_checks++;
    if (mc !== 32'hABC) begin
      n_errors++;
      $display("FAIL w12_mosi got %h want abc", mc);
    end
    n_checks++;
    if (dc !== 27 || ed !== 24) begin
      n_errors++;
      $display("FAIL w12_timing done %0d edges %0d want 27 24", dc, ed);
    end
    n_checks++;
    if (csa !== 4'b1011) begin
      n_errors++;
      $display("FAIL w12_cs got %b want 1011", csa);
    end
    @(negedge clk);
  endtask

  task automatic test_dummy();
    run_xfer(1'b0, 3'd4, 1'b0, 1'b1, 8'd3, 6'd8, 32'h69, 32'h96, 1'b0,
             dc, ed, mc, csf, csa, bf);
    n_checks++;
    if (csf !== 4'hF || csa !== 4'hF) begin
      n_errors++;
      $display("FAIL dummy_cs first %h and %h want F", csf, csa);
    end
    n_checks++;
    if (dc !== 55 || ed !== 16) begin
      n_errors++;
      $display("FAIL dummy_timing done %0d edges %0d want 55 16", dc, ed);
    end
    n_checks++;
    if (o_data_out !== 32'h96 || mc !== 32'h69) begin
      n_errors++;
      $display("FAIL dummy_data rx %h tx %h want 96 69", o_data_out, mc);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int   e;
    int   dones;
    logic prev;
    i_cs_index          = 3'd2;
    i_clock_polarity    = 1'b0;
    i_clock_phase       = 1'b0;
    i_spi_clock_divider = 8'd2;
    i_word_length       = 6'd8;
    i_data_in           = 32'hF0;
    i_spi_miso          = 1'b1;
    i_enable            = 1'b1;
    @(posedge clk);
    @(negedge clk);
    i_enable = 1'b0;
    e        = 0;
    prev     = o_spi_clock;
    for (int c = 0; c < 200 && e < 5; c++) begin
      @(negedge clk);
      if (o_spi_clock !== prev) e++;
      prev = o_spi_clock;
    end
    n_checks++;
    if (e !== 5 || o_busy !== 1'b1) begin
      n_errors++;
      $display("FAIL rm_pre edges %0d busy %b want 5 1", e, o_busy);
    end
    i_reset = 1'b1;
    #1;
    n_checks++;
    if (o_spi_cs_n !== 4'hF || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rm_async cs %h busy %b want F 0", o_spi_cs_n, o_busy);
    end
    n_checks++;
    if (o_spi_clock !== 1'b0 || o_spi_mosi !== 1'b0 ||
        o_data_out !== 32'h0) begin
      n_errors++;
      $display("FAIL rm_pins sclk %b mosi %b data %h want 0 0 0",
               o_spi_clock, o_spi_mosi, o_data_out);
    end
    dones = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 2) i_reset = 1'b0;
      if (o_done === 1'b1) dones++;
    end
    n_checks++;
    if (dones !== 0 || o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL rm_nodone dones %0d busy %b want 0 0", dones, o_busy);
    end
    run_xfer(1'b0, 3'd3, 1'b0, 1'b0, 8'd1, 6'd8, 32'h3C, 32'hC3, 1'b0,
             dc, ed, mc, csf, csa, bf);
    n_checks++;
    if (o_data_out !== 32'hC3 || mc !== 32'h3C) begin
      n_errors++;
      $display("FAIL rm_fresh rx %h tx %h want c3 3c", o_data_out, mc);
    end
    n_checks++;
    if (dc !== 19 || csf !== 4'b0111) begin
      n_errors++;
      $display("FAIL rm_fresh_t done %0d cs %b want 19 0111", dc, csf);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    run_xfer(1'b1, 3'd0, 1'b1, 1'b0, 8'd1, 6'd4, 32'h9, 32'h6, 1'b0,
             dc, ed, mc, csf, csa, bf);
    n_checks++;
    if (dc !== 11 || o_data_out !== 32'h6 || mc !== 32'h9) begin
      n_errors++;
      $display("FAIL b2b_first done %0d rx %h tx %h want 11 6 9",
               dc, o_data_out, mc);
    end
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0 || o_spi_cs_n !== 4'hF || o_spi_clock !== 1'b1) begin
      n_errors++;
      $display("FAIL b2b_gap busy %b cs %h sclk %b want 0 F 1",
               o_busy, o_spi_cs_n, o_spi_clock);
    end
    run_xfer(1'b0, 3'd1, 1'b1, 1'b0, 8'd1, 6'd4, 32'h5, 32'hA, 1'b0,
             dc, ed, mc, csf, csa, bf);
    n_checks++;
    if (bf !== 1'b1 || csf !== 4'b1101) begin
      n_errors++;
      $display("FAIL b2b_restart busy %b cs %b want 1 1101", bf, csf);
    end
    n_checks++;
    if (dc !== 11 || o_data_out !== 32'hA || mc !== 32'h5) begin
      n_errors++;
      $display("FAIL b2b_second done %0d rx %h tx %h want 11 a 5",
               dc, o_data_out, mc);
    end
    @(negedge clk);
  endtask

`ifdef SPI_MULTI_MASTER_LOOPBACK_EN
  task automatic test_loopback();
    i_loopback = 1'b1;
    run_xfer(1'b1, 3'd0, 1'b0, 1'b0, 8'd2, 6'd8, 32'h5A, 32'h0, 1'b1,
             dc, ed, mc, csf, csa, bf);
    n_checks++;
    if (o_data_out !== 32'h0000005A || dc !== 37) begin
      n_errors++;
      $display("FAIL lb_m0 rx %h done %0d want 5a 37", o_data_out, dc);
    end
    @(negedge clk);
    n_checks++;
    if (o_busy !== 1'b0) begin
      n_errors++;
      $display("FAIL lb_gap busy %b want 0", o_busy);
    end
    run_xfer(1'b0, 3'd2, 1'b0, 1'b1, 8'd2, 6'd8, 32'hC3, 32'h0, 1'b1,
             dc, ed, mc, csf, csa, bf);
    n_checks++;
    if (bf !== 1'b1 || o_data_out !== 32'hC3 || dc !== 37) begin
      n_errors++;
      $display("FAIL lb_m1 busy %b rx %h done %0d want 1 c3 37",
               bf, o_data_out, dc);
    end
    i_loopback = 1'b0;
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_mode0();
    test_mode3();
    test_word12();
    test_dummy();
    test_reset_mid();
    test_back_to_back();
`ifdef SPI_MULTI_MASTER_LOOPBACK_EN
    test_loopback();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/spi_multi_master.md
# spi_multi_master

Parametrised SPI master, successor to the single-slave fixed-mode SPI core. Adds N chip selects, runtime CPOL/CPHA, per-transfer word length and an optional internal loopback. It sits between a driver FSM (enable/done/busy handshake) and the board SPI pins, one instance per SPI bus.

## Interface
- SPI_CLOCK_DIVIDER_WIDTH, 8, width of the half-period divider input
- SPI_MAX_DATA_WIDTH, 32, maximum word length in bits (≥2)
- SPI_CS_COUNT, 4, number of chip-select outputs (≥1)
- i_clock  in  1  system clock
- i_reset  in  1  asynchronous, active-high reset
- i_enable  in  1  start request; sampled only while o_busy low
- i_cs_index  in  $clog2(SPI_CS_COUNT+1)  target slave; value ≥ SPI_CS_COUNT = dummy transfer
- i_clock_polarity  in  1  CPOL
- i_clock_phase  in  1  CPHA
- i_spi_clock_divider  in  SPI_CLOCK_DIVIDER_WIDTH  SCLK half-period D in i_clock cycles; 0 treated as 1
- i_word_length  in  $clog2(SPI_MAX_DATA_WIDTH+1)  bits N per transfer; 0 or >MAX treated as MAX
- i_data_in  in  SPI_MAX_DATA_WIDTH  TX word, right-aligned
- o_data_out  out  SPI_MAX_DATA_WIDTH  RX word, right-aligned, upper bits zero
- o_done  out  1  one-cycle pulse at transfer end
- o_busy  out  1  transfer in progress
- o_spi_cs_n  out  SPI_CS_COUNT  active-low selects
- o_spi_clock  out  1  SCLK
- o_spi_mosi  out  1  MOSI
- i_spi_miso  in  1  MISO

## Operation
- Reset values: o_spi_cs_n all 1, o_spi_clock 0, o_spi_mosi 0, o_data_out 0, o_done 0, o_busy 0; state IDLE, latched CPOL 0.
- IDLE: SCLK = latched CPOL, all CS high. i_enable high → latch cs_index, CPOL, CPHA, D, N, i_data_in; go SETUP. All inputs ignored thereafter until IDLE.
- SETUP (D cycles): selected CS low, SCLK = new CPOL, MOSI = bit N-1 (CPHA=0) or held (CPHA=1).
- TRANSFER (2·N·D cycles): SCLK toggles every D cycles, 2N edges. CPHA=0: sample MISO on leading edge, shift MOSI on trailing edge. CPHA=1: shift MOSI on leading edge, sample on trailing edge. MSB first from bit N-1.
- HOLD (D cycles): SCLK at CPOL, CS still low.
- DONE (1 cycle): CS high, o_done=1, o_data_out updated this cycle (holds until next DONE), o_busy still 1; next state IDLE.
- Dummy transfer (cs_index ≥ SPI_CS_COUNT): identical timing, all CS stay high.
- Config changes while busy: no effect on current transfer.

## Timing
- Enable sampled at edge 0; o_busy high from cycle 1; o_done in cycle (2N+2)·D+1; o_busy low the cycle after o_done.
- i_enable held high: next transfer accepted the first cycle o_busy is low (one IDLE cycle between transfers, CS high ≥2 cycles).
- Reset mid-transfer: outputs go to reset values asynchronously; no o_done; partial RX data discarded.
- All outputs registered; no combinational input-to-output paths.

## Configuration
- SPI_MULTI_MASTER_LOOPBACK_EN defined: extra port i_loopback (in, 1), latched at start; when latched high, RX samples internal MOSI, i_spi_miso ignored, pins behave normally.
- Not defined: no i_loopback port; RX always from i_spi_miso.

## Structure
- Package spi_pkg: state enum (IDLE, SETUP, TRANSFER, HOLD, DONE), helper for clamped word length and effective divider.
- Sub-module spi_clock_generator: divider counter producing SCLK level plus leading/trailing edge strobes and half-period tick; FSM and shift registers in top.

## Test plan
- D=2, N=8, CPOL=0/CPHA=0, cs 1, TX 0xA5, slave returns 0x3C -> MOSI 10100101, o_data_out 0x0000003C, only cs_n[1] low, o_done at cycle 37.
- Mode 3, D=1, N=0 (→32), TX 0xDEADBEEF, slave echoes previous word 0x12345678 -> o_data_out 0x12345678, SCLK idles high, o_done at cycle 67.
- N=12, TX 0xFFFFFABC -> exactly 12 SCLK cycles, MOSI 101010111100, o_data_out bits 31:12 zero.
- cs_index 4 with SPI_CS_COUNT=4, N=8 -> all cs_n high throughout, 8 SCLK cycles, o_done pulses.
- i_reset asserted after 5 SCLK edges -> same cycle cs_n all 1, o_busy 0, no o_done; fresh transfer afterwards completes correctly.
- With SPI_MULTI_MASTER_LOOPBACK_EN, i_loopback=1, i_spi_miso=1, TX 0x5A, N=8 -> o_data_out 0x0000005A; with i_enable held high, second transfer starts one cycle after o_busy falls.
